// File: rtl/router_pkg.sv
// Shared router encodings: request directions, input indices and arbiter FSM states,
// plus the round-robin search helpers used by every per-output arbiter.
package router_pkg;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_X     = 2'b01,
        DIR_Y     = 2'b10,
        DIR_LOCAL = 2'b11
    } dir_e;

    localparam logic [1:0] IN_X     = 2'd2;
    localparam logic [1:0] IN_Y     = 2'd1;
    localparam logic [1:0] IN_LOCAL = 2'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Search order is X -> Y -> LOCAL -> X, i.e. descending index with wrap.
    function automatic logic [1:0] next_in(input logic [1:0] idx);
        return (idx == IN_LOCAL) ? IN_X : idx - 2'd1;
    endfunction

    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] start);
        logic [2:0] win;
        logic [1:0] idx;
        win = 3'b000;
        idx = start;
        for (int k = 0; k < 3; k++) begin
            if (win == 3'b000 && req[idx]) begin
                win[idx] = 1'b1;
            end
            idx = next_in(idx);
        end
        return win;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        return oh[IN_X] ? IN_X : (oh[IN_Y] ? IN_Y : IN_LOCAL);
    endfunction

endpackage

// File: rtl/judge_arbiter_if.sv
// Request/result bundle between the router input ports and the judge arbitration stage.
interface judge_arbiter_if;
    logic       enable;
    logic [1:0] dout_x;
    logic [1:0] dout_y;
    logic [1:0] dout_local;
    logic [2:0] fail;
    logic [2:0] busy;
    logic [2:0] starve;

    modport master (
        output enable, dout_x, dout_y, dout_local,
        input  fail, busy, starve
    );

    modport slave (
        input  enable, dout_x, dout_y, dout_local,
        output fail, busy, starve
    );
endinterface

// File: rtl/judge_port_arb.sv
// Arbiter for one output direction: IDLE/BUSY packet FSM with owner, round-robin pointer
// and packet counter; returns a combinational one-hot grant for the current requests.
module judge_port_arb
    import router_pkg::*;
#(
    parameter int PKT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic [2:0] req_i,
    input  logic [2:0] starve_i,
    output logic [2:0] grant_o,
    output logic       busy_o
);
    localparam int CNT_W = $clog2(PKT_LEN + 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       starved_req;
    logic [2:0]       win;

    // Starved requesters take precedence; rr order still breaks ties among them.
    assign starved_req = req_i & starve_i;
    assign win         = rr_pick((starved_req != 3'b000) ? starved_req : req_i, rr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 2'b00;
            rr_q    <= IN_X;
            cnt_q   <= '0;
        end else if (enable_i) begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win != 3'b000) begin
                    owner_d = onehot_idx(win);
                    rr_d    = next_in(owner_d);
                    cnt_d   = CNT_W'(PKT_LEN - 1);
                    state_d = (PKT_LEN > 1) ? ST_BUSY : ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                if (cnt_q == '0 || !req_i[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_o = 3'b000;
        if (enable_i) begin
            case (state_q)
                ST_IDLE: grant_o = win;
                ST_BUSY: grant_o[owner_q] = req_i[owner_q];
                default: grant_o = 3'b000;
            endcase
        end
    end

    assign busy_o = (state_q == ST_BUSY);

endmodule

// File: rtl/judge_arbiter.sv
// Router judge stage: decodes per-input direction requests, arbitrates each output, registers
// the per-input fail vector. Optional starvation override built when JUDGE_STARVE_EN is defined.
module judge_arbiter
    import router_pkg::*;
#(
    parameter int PKT_LEN    = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    judge_arbiter_if.slave  bus
);
    logic [1:0] dout_a  [3];
    logic [2:0] req_v   [3];
    logic [2:0] grant_v [3];
    logic [2:0] valid;
    logic [2:0] grant_any;
    logic [2:0] fail_d, fail_q;
    logic [2:0] busy_w;
    logic [2:0] starve_w;

    assign dout_a[IN_X]     = bus.dout_x;
    assign dout_a[IN_Y]     = bus.dout_y;
    assign dout_a[IN_LOCAL] = bus.dout_local;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_out
            // Output bit gi serves direction code 3-gi (bit 2 = X, bit 0 = LOCAL).
            localparam logic [1:0] DIR_CODE = 2'(3 - gi);
            for (gj = 0; gj < 3; gj++) begin : g_req
                assign req_v[gi][gj] = (dout_a[gj] == DIR_CODE);
            end
            assign valid[gi] = (dout_a[gi] != DIR_NONE);

            judge_port_arb #(.PKT_LEN(PKT_LEN)) u_arb (
                .clk      (clk),
                .rst_n    (rst_n),
                .enable_i (bus.enable),
                .req_i    (req_v[gi]),
                .starve_i (starve_w),
                .grant_o  (grant_v[gi]),
                .busy_o   (busy_w[gi])
            );
        end
    endgenerate

    assign grant_any = grant_v[0] | grant_v[1] | grant_v[2];
    assign fail_d    = valid & ~grant_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= 3'b000;
        end else if (bus.enable) begin
            fail_q <= fail_d;
        end
    end

`ifdef JUDGE_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    generate
        for (gi = 0; gi < 3; gi++) begin : g_starve
            logic [SW-1:0] scnt_q, scnt_d;

            always_comb begin
                scnt_d = scnt_q;
                if (!valid[gi] || grant_any[gi]) begin
                    scnt_d = '0;
                end else if (scnt_q != SW'(STARVE_MAX)) begin
                    scnt_d = scnt_q + SW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    scnt_q <= '0;
                end else if (bus.enable) begin
                    scnt_q <= scnt_d;
                end
            end

            assign starve_w[gi] = (scnt_q == SW'(STARVE_MAX));
        end
    endgenerate
`else
    assign starve_w = 3'b000;
`endif

    assign bus.fail   = fail_q;
    assign bus.busy   = busy_w;
    assign bus.starve = starve_w;

endmodule

// File: tb/tb_judge_arbiter.sv
// Table-driven bench for judge_arbiter (PKT_LEN=4, STARVE_MAX=2) with a small expectation queue.
module tb_judge_arbiter;
    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] L = 2'b11;

`ifdef JUDGE_STARVE_EN
    localparam bit TBL_STARVE = 1'b0;
`else
    localparam bit TBL_STARVE = 1'b1;
`endif

    typedef struct {
        logic       en;
        logic [1:0] dx, dy, dl;
        logic [2:0] fail, busy, starve;
    } vec_t;

    typedef struct {
        logic [2:0] fail, busy, starve;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[22];

    always #5 clk = ~clk;

    judge_arbiter_if bus();

    judge_arbiter #(.PKT_LEN(4), .STARVE_MAX(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic en, input logic [1:0] dx, input logic [1:0] dy,
                                input logic [1:0] dl, input logic [2:0] f, input logic [2:0] b,
                                input logic [2:0] s);
        vec_t v;
        v.en = en; v.dx = dx; v.dy = dy; v.dl = dl;
        v.fail = f; v.busy = b; v.starve = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input bit chk_starve);
        exp_t e;
        exp_t p;
        @(negedge clk);
        bus.enable     = v.en;
        bus.dout_x     = v.dx;
        bus.dout_y     = v.dy;
        bus.dout_local = v.dl;
        p.fail = v.fail; p.busy = v.busy; p.starve = v.starve;
        sb.push_back(p);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        $display("txn %s en=%b x=%b y=%b l=%b -> fail=%b busy=%b starve=%b",
                 tag, v.en, v.dx, v.dy, v.dl, bus.fail, bus.busy, bus.starve);
        check({tag, ".fail"}, bus.fail, e.fail);
        check({tag, ".busy"}, bus.busy, e.busy);
        if (chk_starve) check({tag, ".starve"}, bus.starve, e.starve);
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.dout_x     = N;
        bus.dout_y     = N;
        bus.dout_local = N;

        //              en    x  y  z   fail    busy
        tbl[0]  = mk(1'b1, X, N, N, 3'b000, 3'b100, 3'b000);
        tbl[1]  = mk(1'b1, N, N, N, 3'b000, 3'b000, 3'b000);
        tbl[2]  = mk(1'b1, Y, Y, Y, 3'b011, 3'b010, 3'b000);
        tbl[3]  = mk(1'b1, Y, Y, Y, 3'b011, 3'b010, 3'b000);
        tbl[4]  = mk(1'b1, Y, Y, Y, 3'b011, 3'b010, 3'b000);
        tbl[5]  = mk(1'b1, Y, Y, Y, 3'b011, 3'b010, 3'b000);
        tbl[6]  = mk(1'b1, Y, Y, Y, 3'b011, 3'b000, 3'b000);
        tbl[7]  = mk(1'b1, Y, Y, Y, 3'b101, 3'b010, 3'b000);
        tbl[8]  = mk(1'b1, N, N, N, 3'b000, 3'b000, 3'b000);
        tbl[9]  = mk(1'b1, X, N, N, 3'b000, 3'b100, 3'b000);
        tbl[10] = mk(1'b1, X, N, X, 3'b001, 3'b100, 3'b000);
        tbl[11] = mk(1'b1, X, N, X, 3'b001, 3'b100, 3'b000);
        tbl[12] = mk(1'b1, X, N, X, 3'b001, 3'b100, 3'b000);
        tbl[13] = mk(1'b1, X, N, X, 3'b001, 3'b000, 3'b000);
        tbl[14] = mk(1'b1, X, N, X, 3'b100, 3'b100, 3'b000);
        tbl[15] = mk(1'b1, X, N, X, 3'b100, 3'b100, 3'b000);
        tbl[16] = mk(1'b1, X, N, N, 3'b100, 3'b000, 3'b000);
        tbl[17] = mk(1'b0, Y, Y, Y, 3'b100, 3'b000, 3'b000);
        tbl[18] = mk(1'b1, X, N, N, 3'b000, 3'b100, 3'b000);
        tbl[19] = mk(1'b0, N, Y, L, 3'b000, 3'b100, 3'b000);
        tbl[20] = mk(1'b1, X, Y, L, 3'b000, 3'b111, 3'b000);
        tbl[21] = mk(1'b1, N, N, N, 3'b000, 3'b000, 3'b000);

        repeat (2) @(posedge clk);
        #1;
        check("reset.fail", bus.fail, 3'b000);
        check("reset.busy", bus.busy, 3'b000);
        check("reset.starve", bus.starve, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i], $sformatf("v%0d", i), TBL_STARVE);
        end

        // Asynchronous reset in the middle of a packet, away from any clock edge.
        apply(mk(1'b1, X, X, N, 3'b100, 3'b100, 3'b000), "rst_pre", 1'b1);
        @(posedge clk);
        #1;
        check("rst_midbusy.busy", bus.busy, 3'b100);
        #1 rst_n = 1'b0;
        #1;
        $display("txn async_reset fail=%b busy=%b starve=%b", bus.fail, bus.busy, bus.starve);
        check("rst_async.fail", bus.fail, 3'b000);
        check("rst_async.busy", bus.busy, 3'b000);
        #1 rst_n = 1'b1;
        apply(mk(1'b1, X, X, N, 3'b010, 3'b100, 3'b000), "rst_post", 1'b1);

`ifdef JUDGE_STARVE_EN
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        apply(mk(1'b1, X, N, X, 3'b001, 3'b100, 3'b000), "s1", 1'b1);
        apply(mk(1'b1, X, N, X, 3'b001, 3'b100, 3'b001), "s2", 1'b1);
        apply(mk(1'b1, N, X, X, 3'b011, 3'b000, 3'b001), "s3", 1'b1);
        apply(mk(1'b1, N, X, X, 3'b010, 3'b100, 3'b010), "s4", 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
